program_loader: RTL and testbench

Writer-side companion to the CPU's 256 x 8 instruction memory. It accepts a framed byte stream over a valid/ready handshake and writes the program image into instruction memory, one byte per address starting at `BASE_ADDR`. It holds the CPU while loading, then releases it on success. It sits between the host/serial front end and the instruction memory write port.

---
 rtl/program_loader.sv | 159 +++++++++++++++
 tb/tb_program_loader.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Framed byte-stream loader for the 256 x 8 instruction memory; holds the CPU while loading.
// Optional trailing XOR checksum byte enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start, CPU released
// LEN   | expecting the length byte N
// DATA  | expecting data bytes, each written to BASE_ADDR + index
// CSUM  | expecting the checksum byte (checksum build only)
// DONE  | one-cycle success pulse
// ERR   | failure (timeout or bad checksum), CPU held until start
module program_loader #(
    parameter logic [7:0]  BASE_ADDR      = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES);
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t ST_POST = ST_CSUM;
`else
    localparam state_t ST_POST = ST_DONE;
`endif

    state_t        state, state_nxt;
    logic [7:0]    len;
    logic [7:0]    idx;
    logic [TW-1:0] tmr;
    logic          accept;
    logic          start_acc;
    logic          last_byte;
    logic          tmo_hit;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    assign busy = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
`else
    assign busy = (state == ST_LEN) || (state == ST_DATA);
`endif
    assign rx_ready  = busy;
    assign cpu_hold  = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERR);

    assign accept    = rx_valid && busy;
    assign start_acc = start && ((state == ST_IDLE) || (state == ST_ERR));
    assign last_byte = (idx == (len - 8'd1));
    // Down-counter reloaded on every accepted byte; terminal count of 1 means the budget is spent.
    assign tmo_hit   = TMO_EN && busy && !rx_valid && (tmr == TW'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_LEN;
            end
            ST_LEN: begin
                if (rx_valid)     state_nxt = (rx_data == 8'd0) ? ST_POST : ST_DATA;
                else if (tmo_hit) state_nxt = ST_ERR;
            end
            ST_DATA: begin
                if (rx_valid) begin
                    if (last_byte) state_nxt = ST_POST;
                end else if (tmo_hit) begin
                    state_nxt = ST_ERR;
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_valid)     state_nxt = (rx_data == csum) ? ST_DONE : ST_ERR;
                else if (tmo_hit) state_nxt = ST_ERR;
            end
`endif
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR: begin
                if (start) state_nxt = ST_LEN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len       <= 8'd0;
            idx       <= 8'd0;
            tmr       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= 8'd0;
            mem_wdata <= 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            mem_we <= 1'b0;

            if (start_acc || accept) begin
                tmr <= TMR_LOAD;
            end else if (busy && (tmr != '0)) begin
                tmr <= tmr - TW'(1);
            end

            if (accept && (state == ST_LEN)) begin
                len <= rx_data;
                idx <= 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum <= 8'd0;
`endif
            end

            // Address arithmetic is 8-bit so images past 0xFF wrap to 0.
            if (accept && (state == ST_DATA)) begin
                mem_we    <= 1'b1;
                mem_addr  <= BASE_ADDR + idx;
                mem_wdata <= rx_data;
                idx       <= idx + 8'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                csum      <= csum ^ rx_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (base 0x00 / long timeout, base 0xFE / timeout 8)
// share one randomized stream and are checked every cycle against a frame-level model.
module tb_program_loader;

    localparam int M_IDLE = 0, M_LEN = 1, M_DATA = 2, M_CSUM = 3, M_DONE = 4, M_ERR = 5;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       rx_valid;
    logic [7:0] rx_data;

    logic       rdy  [2];
    logic       mwe  [2];
    logic [7:0] maddr[2];
    logic [7:0] mwd  [2];
    logic       hold [2];
    logic       bsy  [2];
    logic       dn   [2];
    logic       err  [2];

    program_loader #(.BASE_ADDR(8'h00), .TIMEOUT_CYCLES(1024)) u_a (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy[0]), .mem_we(mwe[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
        .cpu_hold(hold[0]), .busy(bsy[0]), .done(dn[0]), .error(err[0])
    );

    program_loader #(.BASE_ADDR(8'hFE), .TIMEOUT_CYCLES(8)) u_b (
        .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rdy[1]), .mem_we(mwe[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
        .cpu_hold(hold[1]), .busy(bsy[1]), .done(dn[1]), .error(err[1])
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] base_of(input int d);
        return (d == 1) ? 8'hFE : 8'h00;
    endfunction

    function automatic int timeout_of(input int d);
        return (d == 1) ? 8 : 1024;
    endfunction

    // Frame-level model: what phase of the frame each loader is in and what it must write.
    int         mode   [2] = '{default: 0};
    int         n_m    [2] = '{default: 0};
    int         cnt_m  [2] = '{default: 0};
    int         idle_m [2] = '{default: 0};
    logic [7:0] x_m    [2] = '{default: 8'h00};
    bit         we_m   [2] = '{default: 1'b0};
    logic [7:0] addr_m [2] = '{default: 8'h00};
    logic [7:0] wd_m   [2] = '{default: 8'h00};

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                mode[d] = M_IDLE; n_m[d] = 0; cnt_m[d] = 0; idle_m[d] = 0;
                x_m[d] = 8'h00; we_m[d] = 1'b0; addr_m[d] = 8'h00; wd_m[d] = 8'h00;
            end else begin
                bit was_busy;
                bit acc;
                was_busy = (mode[d] == M_LEN) || (mode[d] == M_DATA) || (mode[d] == M_CSUM);
                acc      = rx_valid && was_busy;
                we_m[d]  = 1'b0;
                case (mode[d])
                    M_IDLE, M_ERR: if (start) begin mode[d] = M_LEN; idle_m[d] = 0; end
                    M_DONE: mode[d] = M_IDLE;
                    M_LEN: if (acc) begin
                        n_m[d] = int'(rx_data); cnt_m[d] = 0; x_m[d] = 8'h00;
                        if (rx_data == 8'h00) mode[d] = CS ? M_CSUM : M_DONE;
                        else                  mode[d] = M_DATA;
                    end
                    M_DATA: if (acc) begin
                        we_m[d]   = 1'b1;
                        addr_m[d] = 8'((int'(base_of(d)) + cnt_m[d]) % 256);
                        wd_m[d]   = rx_data;
                        x_m[d]    = x_m[d] ^ rx_data;
                        cnt_m[d]++;
                        if (cnt_m[d] == n_m[d]) mode[d] = CS ? M_CSUM : M_DONE;
                    end
                    M_CSUM: if (acc) mode[d] = (rx_data == x_m[d]) ? M_DONE : M_ERR;
                    default: mode[d] = M_IDLE;
                endcase
                if (acc) idle_m[d] = 0;
                else if (was_busy) begin
                    idle_m[d]++;
                    if (idle_m[d] == timeout_of(d)) mode[d] = M_ERR;
                end
            end
        end
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mem_log [2][256];
    int         wr_cnt  [2] = '{default: 0};
    int         done_cnt[2] = '{default: 0};

    task automatic chk(input string nm, input int d, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            int eb;
            eb = ((mode[d] == M_LEN) || (mode[d] == M_DATA) || (mode[d] == M_CSUM)) ? 1 : 0;
            chk("rx_ready", d, int'(rdy[d]), eb);
            chk("busy",     d, int'(bsy[d]), eb);
            chk("cpu_hold", d, int'(hold[d]), (mode[d] != M_IDLE) ? 1 : 0);
            chk("done",     d, int'(dn[d]),  (mode[d] == M_DONE) ? 1 : 0);
            chk("error",    d, int'(err[d]), (mode[d] == M_ERR) ? 1 : 0);
            chk("mem_we",   d, int'(mwe[d]), int'(we_m[d]));
            if (we_m[d] || reset) begin
                chk("mem_addr",  d, int'(maddr[d]), int'(addr_m[d]));
                chk("mem_wdata", d, int'(mwd[d]),   int'(wd_m[d]));
            end
            if (mwe[d]) begin
                mem_log[d][maddr[d]] = mwd[d];
                wr_cnt[d]++;
            end
            if (dn[d]) done_cnt[d]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int         w0, w1, d0, d1, n, gap;
        logic [7:0] b, xs, cs;
        reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        tick(); tick();
        reset = 1'b0;

        // Idle after reset: nothing is accepted even with rx_valid high.
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick(); tick();
        chk("idle_rx_ready", 0, int'(rdy[0]), 0);
        chk("idle_cpu_hold", 0, int'(hold[0]), 0);
        chk("idle_mem_we",   0, int'(mwe[0]), 0);
        chk("idle_error",    0, int'(err[0]), 0);
        rx_valid = 1'b0;

        // Basic three-byte load at base 0.
        w0 = wr_cnt[0]; d0 = done_cnt[0];
        pulse_start();
        send(8'h03); send(8'h0A); send(8'h0B); send(8'h0C);
        if (CS) send(8'h0D);
        chk("basic_done_pulse", 0, int'(dn[0]), 1);
        chk("basic_hold_in_done", 0, int'(hold[0]), 1);
        tick();
        chk("basic_hold_falls", 0, int'(hold[0]), 0);
        chk("basic_done_clears", 0, int'(dn[0]), 0);
        tick();
        chk("basic_writes", 0, wr_cnt[0] - w0, 3);
        chk("basic_mem0", 0, int'(mem_log[0][0]), 8'h0A);
        chk("basic_mem1", 0, int'(mem_log[0][1]), 8'h0B);
        chk("basic_mem2", 0, int'(mem_log[0][2]), 8'h0C);
        chk("basic_done_count", 0, done_cnt[0] - d0, 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // Bad checksum: error sticks until the next start.
        do_reset();
        d0 = done_cnt[0];
        pulse_start();
        send(8'h02); send(8'h11); send(8'h22); send(8'h00);
        chk("bad_csum_error", 0, int'(err[0]), 1);
        tick(); tick(); tick();
        chk("bad_csum_sticky", 0, int'(err[0]), 1);
        chk("bad_csum_hold", 0, int'(hold[0]), 1);
        chk("bad_csum_no_done", 0, done_cnt[0] - d0, 0);
        pulse_start();
        chk("restart_clears_error", 0, int'(err[0]), 0);
        chk("restart_busy", 0, int'(bsy[0]), 1);
`endif

        // Empty program.
        do_reset();
        w0 = wr_cnt[0]; d0 = done_cnt[0];
        pulse_start();
        send(8'h00);
        if (CS) send(8'h00);
        chk("empty_done", 0, int'(dn[0]), 1);
        tick();
        chk("empty_writes", 0, wr_cnt[0] - w0, 0);
        chk("empty_done_count", 0, done_cnt[0] - d0, 1);

        // Address wrap on the 0xFE-based loader.
        do_reset();
        w1 = wr_cnt[1];
        pulse_start();
        send(8'h03); send(8'hA1); send(8'hA2); send(8'hA3);
        if (CS) send(8'hA0);
        tick(); tick();
        chk("wrap_memFE", 1, int'(mem_log[1][8'hFE]), 8'hA1);
        chk("wrap_memFF", 1, int'(mem_log[1][8'hFF]), 8'hA2);
        chk("wrap_mem00", 1, int'(mem_log[1][8'h00]), 8'hA3);
        chk("wrap_no_error", 1, int'(err[1]), 0);
        chk("wrap_writes", 1, wr_cnt[1] - w1, 3);

        // Timeout of 8 idle cycles on the second loader.
        do_reset();
        w1 = wr_cnt[1];
        pulse_start();
        send(8'h04); send(8'h01);
        repeat (7) tick();
        chk("tmo_not_yet", 1, int'(err[1]), 0);
        chk("tmo_still_busy", 1, int'(bsy[1]), 1);
        tick();
        chk("tmo_error", 1, int'(err[1]), 1);
        chk("tmo_hold", 1, int'(hold[1]), 1);
        chk("tmo_one_write", 1, wr_cnt[1] - w1, 1);
        chk("tmo_long_still_busy", 0, int'(bsy[0]), 1);

        // Reset in the middle of a frame, then a clean reload.
        do_reset();
        pulse_start();
        send(8'h05); send(8'h11); send(8'h22);
        reset = 1'b1;
        #1;
        chk("midreset_mem_we", 0, int'(mwe[0]), 0);
        chk("midreset_hold", 0, int'(hold[0]), 0);
        chk("midreset_busy", 0, int'(bsy[0]), 0);
        tick();
        reset = 1'b0;
        d0 = done_cnt[0]; d1 = done_cnt[1];
        pulse_start();
        send(8'h01); send(8'h55);
        if (CS) send(8'h55);
        tick(); tick();
        chk("reload_mem_a", 0, int'(mem_log[0][8'h00]), 8'h55);
        chk("reload_mem_b", 1, int'(mem_log[1][8'hFE]), 8'h55);
        chk("reload_done_a", 0, done_cnt[0] - d0, 1);
        chk("reload_done_b", 1, done_cnt[1] - d1, 1);

        // Randomized frames with gaps, stray starts and corrupted checksums.
        repeat (40) begin
            do_reset();
            if ($urandom_range(0, 1) == 1) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
            end
            pulse_start();
            rx_valid = 1'b0;
            n  = $urandom_range(0, 12);
            xs = 8'h00;
            send(8'(n));
            for (int i = 0; i < n; i++) begin
                gap = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 2);
                repeat (gap) tick();
                b = 8'($urandom);
                xs = xs ^ b;
                if ($urandom_range(0, 7) == 0) start = 1'b1;
                send(b);
                start = 1'b0;
            end
            cs = xs;
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            repeat ($urandom_range(0, 2)) tick();
            if (CS) send(cs);
            repeat (3) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
